// File: rtl/mem_responder.sv
// Memory-bus target: word RAM plus an MMIO window with a console TX FIFO,
// a STATUS/error register and a free-running cycle counter.
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        data_rw,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [7:0]    count;
    logic          ovf;
    logic          err;
    logic [31:0]   cycles;

    logic [AW-1:0] ram_idx;
    logic [5:0]    offset;
    logic          is_ram;
    logic          is_mmio;
    logic          unmapped;
    logic          sel_console;
    logic          sel_status;
    logic          sel_cycles;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          push_ok;
    logic [31:0]   status_word;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^address[1:0];

    assign ram_idx     = address[AW+1:2];
    assign offset      = address[7:2];
    assign is_ram      = (address[31:AW+2] == '0);
    assign is_mmio     = (address[31:8] == MMIO_BASE[31:8]);
    assign unmapped    = !is_ram && !is_mmio;
    assign sel_console = is_mmio && (offset == 6'd0);
    assign sel_status  = is_mmio && (offset == 6'd1);
    assign sel_cycles  = is_mmio && (offset == 6'd2);

    assign empty    = (count == 8'd0);
    assign full     = (count == 8'(FIFO_DEPTH));
    assign tx_valid = !empty;
    // Head slot is not reset, so mask it to keep tx_data at zero when idle.
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign bus_err  = err;

    assign pop     = tx_valid && tx_ready;
    assign push    = data_rw && sel_console;
    assign push_ok = push && (!full || pop);

    assign status_word = {16'b0, count, 4'b0, err, ovf, full, empty};

    always_comb begin
        rdata = 32'h0;
        if (is_ram) begin
            rdata = ram[ram_idx];
        end else if (is_mmio) begin
            case (offset)
                6'd1:    rdata = status_word;
                6'd2:    rdata = cycles;
                default: rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (data_rw && is_ram) begin
            ram[ram_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    // Any edge with an unmapped address sets err, whether read or write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 8'd0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            cycles <= 32'h0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 8'd1;
                2'b01:   count <= count - 8'd1;
                default: count <= count;
            endcase

            cycles <= (data_rw && sel_cycles) ? wdata : cycles + 32'd1;

            if (push && !push_ok) begin
                ovf <= 1'b1;
            end else if (data_rw && sel_status && wdata[2]) begin
                ovf <= 1'b0;
            end

            if (unmapped) begin
                err <= 1'b1;
            end else if (data_rw && sel_status && wdata[3]) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder; expected bytes and read data
// are queued at stimulus time and compared by a negedge monitor.
module tb_mem_responder;

    localparam int          FD      = 8;
    localparam logic [31:0] BASE    = 32'hFFFF_FF00;
    localparam logic [31:0] CONSOLE = BASE;
    localparam logic [31:0] STATUS  = BASE + 32'h4;
    localparam logic [31:0] CYCLES  = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        data_rw = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    logic        rd_chk = 1'b0;
    logic [31:0] ram_m [int];
    logic        m_ovf = 1'b0;
    logic        m_err = 1'b0;
    int unsigned edge_cnt = 0;
    logic [31:0] cyc_load_val = 32'h0;
    int unsigned cyc_load_edge = 0;

    mem_responder #(
        .DEPTH_WORDS(1024),
        .FIFO_DEPTH (FD),
        .MMIO_BASE  (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .wdata   (wdata),
        .data_rw (data_rw),
        .rdata   (rdata),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    function automatic logic [31:0] cyc_now();
        return cyc_load_val + 32'(edge_cnt - cyc_load_edge);
    endfunction

    function automatic logic [31:0] status_now();
        int n;
        n = exp_q.size();
        return {16'b0, 8'(n), 4'b0, m_err, m_ovf, (n == FD), (n == 0)};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: TX handshake, error flag and queued read data are checked on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            check_output("tx_valid", {31'b0, tx_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                check_output("tx_data", {24'b0, tx_data}, {24'b0, exp_q[0]});
                if (tx_ready) void'(exp_q.pop_front());
            end
            check_output("bus_err", {31'b0, bus_err}, {31'b0, m_err});
            if (rd_chk) begin
                if (rd_q.size() > 0) check_output(rd_name_q.pop_front(), rdata, rd_q.pop_front());
                else check_output("rd_queue_empty", 32'h1, 32'h0);
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        int occ;
        bit pop_now;
        w = {a[31:2], 2'b00};
        occ = exp_q.size();
        pop_now = tx_ready && (occ > 0);
        address = a;
        wdata = d;
        data_rw = 1'b1;
        @(posedge clk);
        #1;
        data_rw = 1'b0;
        address = 32'h0;
        if (w < 32'h1000) ram_m[int'(w >> 2)] = d;
        else if (w == CONSOLE) begin
            if (occ < FD || pop_now) exp_q.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end else if (w == STATUS) begin
            if (d[2]) m_ovf = 1'b0;
            if (d[3]) m_err = 1'b0;
        end else if (w == CYCLES) begin
            cyc_load_val = d;
            cyc_load_edge = edge_cnt;
        end else if (w < BASE) m_err = 1'b1;
    endtask

    task automatic do_read(input logic [31:0] a, input string name);
        logic [31:0] w;
        logic [31:0] e;
        w = {a[31:2], 2'b00};
        e = 32'h0;
        if (w < 32'h1000) e = ram_m[int'(w >> 2)];
        else if (w == STATUS) e = status_now();
        else if (w == CYCLES) e = cyc_now();
        address = a;
        data_rw = 1'b0;
        rd_q.push_back(e);
        rd_name_q.push_back(name);
        rd_chk = 1'b1;
        @(posedge clk);
        #1;
        rd_chk = 1'b0;
        address = 32'h0;
        if (w >= 32'h1000 && w < BASE) m_err = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        cyc_load_val = 32'h0;
        cyc_load_edge = edge_cnt;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int op;
        int idx;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_output("reset_bus_err", {31'b0, bus_err}, 32'h0);
        release_reset();
        do_read(STATUS, "status_after_reset");
        do_read(CYCLES, "cycles_after_reset");

        $display("[TB] RAM write/read");
        do_write(32'h14, 32'h1234_5678);
        do_write(32'h10, 32'hDEAD_BEEF);
        do_read(32'h10, "ram_raw");
        do_read(32'h13, "ram_low_bits");
        do_read(32'h14, "ram_neighbor");

        $display("[TB] Console ordering");
        tx_ready = 1'b0;
        do_write(CONSOLE, 32'h41);
        do_write(CONSOLE, 32'h42);
        do_write(CONSOLE, 32'h43);
        do_read(STATUS, "status_three_queued");
        tx_ready = 1'b1;
        idle(3);
        check_output("drained_three", {31'b0, tx_valid}, 32'h0);

        $display("[TB] Overflow");
        tx_ready = 1'b0;
        for (int i = 0; i < FD + 1; i++) do_write(CONSOLE, 32'h60 + 32'(i));
        do_read(STATUS, "status_overflow");
        do_write(STATUS, 32'h4);
        do_read(STATUS, "status_ovf_cleared");

        $display("[TB] Push while full with pop");
        tx_ready = 1'b1;
        do_write(CONSOLE, 32'h5A);
        idle(FD + 2);
        check_output("drained_full", {31'b0, tx_valid}, 32'h0);
        do_read(STATUS, "status_after_full_pop");

        $display("[TB] Unmapped access");
        do_read(32'h8000_0000, "unmapped_rdata");
        check_output("bus_err_set", {31'b0, bus_err}, 32'h1);
        do_write(STATUS, 32'h8);
        check_output("bus_err_cleared", {31'b0, bus_err}, 32'h0);

        $display("[TB] Cycle counter wrap");
        do_write(CYCLES, 32'hFFFF_FFFE);
        do_read(CYCLES, "cycles_load");
        do_read(CYCLES, "cycles_max");
        do_read(CYCLES, "cycles_wrap");

        $display("[TB] Reset mid-drain");
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_write(CONSOLE, 32'h70 + 32'(i));
        tx_ready = 1'b1;
        idle(1);
        reset = 1'b0;
        #1;
        check_output("reset_async_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_output("reset_async_tx_data", {24'b0, tx_data}, 32'h0);
        exp_q.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        release_reset();
        do_read(STATUS, "status_after_mid_reset");
        do_read(CYCLES, "cycles_after_mid_reset");

        $display("[TB] Random traffic");
        for (int n = 0; n < 300; n++) begin
            tx_ready = ($urandom_range(0, 2) == 0);
            op = $urandom_range(0, 9);
            idx = $urandom_range(0, 31);
            case (op)
                0, 1: do_write(32'(idx * 4) + 32'($urandom_range(0, 3)), $urandom);
                2: begin
                    if (ram_m.exists(idx)) do_read(32'(idx * 4) + 32'($urandom_range(0, 3)), "rand_ram");
                    else do_write(32'(idx * 4), $urandom);
                end
                3, 4: do_write(CONSOLE, $urandom);
                5: do_read(STATUS, "rand_status");
                6: do_write(STATUS, $urandom);
                7: begin
                    if ($urandom_range(0, 3) == 0) do_write(CYCLES, $urandom);
                    else do_read(CYCLES, "rand_cycles");
                end
                8: begin
                    a = 32'h0001_0000 | ($urandom & 32'h0FFF_FFFC);
                    case ($urandom_range(0, 3))
                        0: do_read(a, "rand_unmapped");
                        1: do_write(a, $urandom);
                        2: do_read(BASE + 32'(4 * $urandom_range(3, 63)), "rand_mmio_hole");
                        default: do_write(BASE + 32'(4 * $urandom_range(3, 63)), $urandom);
                    endcase
                end
                default: idle(1);
            endcase
        end
        tx_ready = 1'b1;
        idle(FD + 2);
        check_output("final_drain", {31'b0, tx_valid}, 32'h0);
        do_read(STATUS, "final_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
